// File: rtl/argmax_select.sv
// Streams LENGTH IEEE-754 single-precision words from the activation BRAM and
// writes the index and bits of the largest non-NaN value to the result BRAM.
module argmax_select #(
    parameter int BRAM_WIDTH = 32,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int LENGTH     = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           ps_control,
    output logic [31:0]           pl_status,
    output logic [ADDR_WIDTH-1:0] bram_addr_in,
    input  logic [BRAM_WIDTH-1:0] bram_rddata_in,
    output logic [BRAM_WIDTH-1:0] bram_wrdata_in,
    output logic [WORD_BYTES-1:0] bram_we_in,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    input  logic [BRAM_WIDTH-1:0] bram_rddata_out,
    output logic [BRAM_WIDTH-1:0] bram_wrdata_out,
    output logic [WORD_BYTES-1:0] bram_we_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(LENGTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(WORD_BYTES);
    localparam logic [BRAM_WIDTH-1:0] SIGN_BIT   = {1'b1, {(BRAM_WIDTH-1){1'b0}}};
    localparam logic [BRAM_WIDTH-1:0] NO_IDX     = '1;
    localparam logic [BRAM_WIDTH-1:0] QUIET_NAN  = BRAM_WIDTH'(32'h7FC0_0000);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WR_IDX,
        WR_VAL,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic                  start;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_vld;
    logic [ADDR_WIDTH-1:0] dat_idx;
    logic                  dat_vld;
    logic                  best_valid;
    logic [BRAM_WIDTH-1:0] best_val;
    logic [ADDR_WIDTH-1:0] best_idx;
    logic                  nan_seen;
    logic                  word_is_nan;
    logic                  word_wins;
    logic                  unused_bits;

    // Maps float bits onto an unsigned key with the same ordering as the values.
    function automatic logic [BRAM_WIDTH-1:0] order_key(input logic [BRAM_WIDTH-1:0] x);
        return x[BRAM_WIDTH-1] ? ~x : (x ^ SIGN_BIT);
    endfunction

    assign start       = ps_control[0];
    assign unused_bits = ^{ps_control[31:1], bram_rddata_out};

    assign word_is_nan = (bram_rddata_in[30:23] == 8'hFF) && (bram_rddata_in[22:0] != 23'd0);
    assign word_wins   = !best_valid || (order_key(bram_rddata_in) > order_key(best_val));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state      = state;
        bram_we_out     = '0;
        bram_addr_out   = '0;
        bram_wrdata_out = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = READ;
                end
            end
            READ: begin
                if (rd_idx == LAST_IDX) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                next_state = WR_IDX;
            end
            WR_IDX: begin
                bram_we_out     = '1;
                bram_addr_out   = '0;
                bram_wrdata_out = best_valid ? BRAM_WIDTH'(best_idx) : NO_IDX;
                next_state      = WR_VAL;
            end
            WR_VAL: begin
                bram_we_out     = '1;
                bram_addr_out   = ADDR_STEP;
                bram_wrdata_out = best_valid ? best_val : QUIET_NAN;
                next_state      = DONE;
            end
            DONE: begin
                if (!start) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Read issue, one-cycle BRAM latency alignment and running best tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr       <= '0;
            rd_idx     <= '0;
            rd_vld     <= 1'b0;
            dat_idx    <= '0;
            dat_vld    <= 1'b0;
            best_valid <= 1'b0;
            best_val   <= '0;
            best_idx   <= '0;
            nan_seen   <= 1'b0;
        end else begin
            rd_vld  <= 1'b0;
            dat_vld <= rd_vld;
            dat_idx <= rd_idx;
            if (state == IDLE && start) begin
                addr       <= '0;
                rd_idx     <= '0;
                rd_vld     <= 1'b1;
                best_valid <= 1'b0;
                nan_seen   <= 1'b0;
            end else if (state == READ && rd_idx != LAST_IDX) begin
                addr   <= addr + ADDR_STEP;
                rd_idx <= rd_idx + 1'b1;
                rd_vld <= 1'b1;
            end
            if (dat_vld) begin
                if (word_is_nan) begin
                    nan_seen <= 1'b1;
                end else if (word_wins) begin
                    best_valid <= 1'b1;
                    best_val   <= bram_rddata_in;
                    best_idx   <= dat_idx;
                end
            end
        end
    end

    assign bram_addr_in   = addr;
    assign bram_wrdata_in = '0;
    assign bram_we_in     = '0;
    assign pl_status      = {30'd0, nan_seen, (state == DONE)};

endmodule

// File: tb/tb_argmax_select.sv
// Scoreboarded bench for argmax_select: directed BRAM images, expected result
// writes queued at start and checked by an independent write monitor.
module tb_argmax_select;

    localparam int BW  = 32;
    localparam int WB  = 4;
    localparam int AW  = 12;
    localparam int LEN = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   ps_control = '0;
    logic [31:0]   pl_status;
    logic [AW-1:0] bram_addr_in;
    logic [BW-1:0] bram_rddata_in;
    logic [BW-1:0] bram_wrdata_in;
    logic [WB-1:0] bram_we_in;
    logic [AW-1:0] bram_addr_out;
    logic [BW-1:0] bram_rddata_out = '0;
    logic [BW-1:0] bram_wrdata_out;
    logic [WB-1:0] bram_we_out;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] mem_in [0:1023];
    int          vectors = 0;
    int          miscompares = 0;

    argmax_select #(
        .BRAM_WIDTH(BW),
        .WORD_BYTES(WB),
        .ADDR_WIDTH(AW),
        .LENGTH    (LEN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ps_control     (ps_control),
        .pl_status      (pl_status),
        .bram_addr_in   (bram_addr_in),
        .bram_rddata_in (bram_rddata_in),
        .bram_wrdata_in (bram_wrdata_in),
        .bram_we_in     (bram_we_in),
        .bram_addr_out  (bram_addr_out),
        .bram_rddata_out(bram_rddata_out),
        .bram_wrdata_out(bram_wrdata_out),
        .bram_we_out    (bram_we_out)
    );

    always #5 clk = ~clk;

    // Registered-read model of the activation BRAM.
    always @(posedge clk) begin
        bram_rddata_in <= mem_in[bram_addr_in[AW-1:2]];
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every result-BRAM write must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t e;
        if (bram_we_out !== '0 || bram_we_in !== '0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected write: addr %h data %h we %h", bram_addr_out,
                         bram_wrdata_out, bram_we_out);
            end else begin
                e = exp_q.pop_front();
                check_output("wr_addr", 32'(bram_addr_out), 32'(e.addr));
                check_output("wr_data", bram_wrdata_out, e.data);
                check_output("wr_we", 32'(bram_we_out), 32'hF);
            end
        end
    end

    function automatic logic [31:0] int_to_float(input int k);
        int p;
        logic [31:0] m;
        if (k == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 24; i++) if (k[i]) p = i;
        m = (32'(k) << (23 - p)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 1024; i++) mem_in[i] = v;
    endtask

    // Runs one start/done handshake; hold keeps start high that many cycles after done.
    task automatic apply_stimulus(input string name, input logic [31:0] exp_idx,
                                  input logic [31:0] exp_val, input logic exp_nan,
                                  input int hold);
        int n;
        int low_cnt;
        exp_q.push_back('{addr: AW'(0), data: exp_idx});
        exp_q.push_back('{addr: AW'(4), data: exp_val});
        @(negedge clk);
        ps_control = 32'h1;
        @(posedge clk);
        n = 0;
        while (!pl_status[0] && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output({name, " latency"}, 32'(n), 32'(LEN + 3));
        check_output({name, " nan flag"}, 32'(pl_status[1]), 32'(exp_nan));
        check_output({name, " pending writes"}, 32'(exp_q.size()), 32'd0);
        if (hold > 0) begin
            low_cnt = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (!pl_status[0]) low_cnt++;
            end
            check_output({name, " done held"}, 32'(low_cnt), 32'd0);
        end
        @(negedge clk);
        ps_control = 32'h0;
        @(posedge clk);
        #1;
        check_output({name, " done drop"}, 32'(pl_status[0]), 32'd0);
    endtask

    initial begin
        fill(32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_output("reset status", pl_status, 32'h0);
        check_output("reset addr_in", 32'(bram_addr_in), 32'h0);
        check_output("reset we_out", 32'(bram_we_out), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < LEN; i++) mem_in[i] = int_to_float(i);
        apply_stimulus("ramp", 32'd511, 32'h43FF_8000, 1'b0, 0);

        fill(32'h0);
        apply_stimulus("all zero", 32'd0, 32'h0, 1'b0, 0);

        fill(32'hBF80_0000);
        mem_in[3]  = 32'h8000_0000;
        mem_in[7]  = 32'h0000_0000;
        mem_in[10] = 32'h4020_0000;
        mem_in[20] = 32'h4020_0000;
        apply_stimulus("signs ties", 32'd10, 32'h4020_0000, 1'b0, 0);

        fill(32'hBF80_0000);
        mem_in[9]   = 32'hBF00_0000;
        mem_in[300] = 32'hFF80_0000;
        apply_stimulus("negatives", 32'd9, 32'hBF00_0000, 1'b0, 0);

        fill(32'h3F80_0000);
        mem_in[0] = 32'h7FC0_0000;
        mem_in[5] = 32'h7F80_0000;
        apply_stimulus("nan inf", 32'd5, 32'h7F80_0000, 1'b1, 0);

        fill(32'h7FC0_0000);
        mem_in[17]  = 32'hFFC0_0001;
        mem_in[200] = 32'h7F80_0001;
        apply_stimulus("all nan", 32'hFFFF_FFFF, 32'h7FC0_0000, 1'b1, 0);

        fill(32'hC000_0000);
        mem_in[42] = 32'h4100_0000;
        apply_stimulus("handshake", 32'd42, 32'h4100_0000, 1'b0, 50);
        apply_stimulus("rerun", 32'd42, 32'h4100_0000, 1'b0, 0);

        // Abort a run mid-scan; no expectations queued, so any write is flagged.
        @(negedge clk);
        ps_control = 32'h1;
        @(posedge clk);
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_output("abort status", pl_status, 32'h0);
        check_output("abort addr_in", 32'(bram_addr_in), 32'h0);
        check_output("abort addr_out", 32'(bram_addr_out), 32'h0);
        check_output("abort wrdata", bram_wrdata_out, 32'h0);
        check_output("abort we_out", 32'(bram_we_out), 32'h0);
        ps_control = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (LEN + 10) @(posedge clk);
        #1;
        check_output("post abort status", pl_status, 32'h0);
        apply_stimulus("after abort", 32'd42, 32'h4100_0000, 1'b0, 0);

        repeat (5) @(posedge clk);
        check_output("final pending writes", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
